fifo_rate_ctrl: RTL and testbench
=================================

FIFO_RATE_CTRL -- requirements
Module: fifo_rate_ctrl

Interface
REQ-001 Parameter DATA_W, default 12, sample width.
REQ-002 Parameter DEPTH, default 2048, FIFO capacity in samples.
REQ-003 Parameter PREFILL, default 1024, occupancy needed to leave PREFILL; 1 <= PREFILL <= DEPTH.
REQ-004 Parameter PHASE_W, default 16, step width, unsigned Q1.15.
REQ-005 clock  in  1  single clock; one clock, reset is synchronous and active-high.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 in_valid  in  1  input sample strobe, one cycle per sample.
REQ-008 in_data  in  DATA_W  input sample.
REQ-009 out_strobe  in  1  output-rate tick, one cycle.
REQ-010 step  in  PHASE_W  resample ratio Q1.15; 0x8000 = unity; sampled on out_strobe.
REQ-011 clear_flags  in  1  clears overrun/underrun.
REQ-012 fifo_enqueue, fifo_dequeue  out  1  FIFO controls.
REQ-013 fifo_data_in  out  DATA_W  FIFO write data.
REQ-014 fifo_data_out  in  DATA_W; fifo_data_valid, fifo_full, fifo_empty  in  1  FIFO status.
REQ-015 out_valid  out  1  one-cycle pulse per out_strobe; out_data  out  DATA_W.
REQ-016 level  out  clog2(DEPTH+1)  occupancy; state  out  1  0=PREFILL,1=RUN; overrun, underrun  out  1  sticky.

Function
REQ-017 Enqueue: in_valid and not fifo_full and level<DEPTH -> fifo_enqueue=1, fifo_data_in=in_data, same cycle (combinational pass-through).
REQ-018 in_valid while full -> sample dropped, no enqueue, overrun=1 next cycle.
REQ-019 level: +1 on enqueue, -1 on dequeue, unchanged when both same cycle; never exceeds DEPTH or goes below 0.
REQ-020 PREFILL: out_strobe -> out_valid next cycle with out_data=0; no dequeues; accumulator held at 0.
REQ-021 PREFILL->RUN in the cycle after level >= PREFILL.
REQ-022 RUN, out_strobe: sum = acc + step (PHASE_W+1 bits); acc <= sum[14:0]; n = sum[16:15] (0..2) added to pending counter (3 bits, saturating at 7).
REQ-023 While pending>0 and level>0: fifo_dequeue=1 for one cycle, pending-1; at most one dequeue per clock; never dequeue when level==0 or fifo_empty.
REQ-024 FIFO read latency fixed: fifo_data_valid one cycle after fifo_dequeue; controller registers fifo_data_out as held sample.
REQ-025 out_valid pulses the cycle after the last fifo_data_valid of a strobe's dequeues; n=0 -> out_valid the cycle after strobe with held sample repeated.
REQ-026 Latency strobe->out_valid: n=0: 1 cycle; n=1: 3 cycles; n=2: 4 cycles.
REQ-027 out_strobe while pending>0: n added to pending; one out_valid per strobe, in order.
REQ-028 Underrun: RUN, pending>0 and level==0 -> underrun=1, pending=0, acc=0, state PREFILL, out_valid with out_data=0 for outstanding strobe(s).
REQ-029 clear_flags clears both flags next cycle; a same-cycle set event wins.
REQ-030 Enqueue and dequeue in same cycle both permitted, including at level==DEPTH (dequeue first frees slot is NOT assumed: enqueue blocked if fifo_full).

Reset
REQ-031 On reset: state=PREFILL, acc=0, pending=0, level=0, held sample=0, out_data=0, out_valid=0, fifo_enqueue=0, fifo_dequeue=0, overrun=0, underrun=0.
REQ-032 Reset mid-operation abandons pending dequeues; FIFO is reset by the same reset; in-flight fifo_data_valid ignored.

Structure
REQ-033 Package fifo_ctrl_pkg holds DATA_W, DEPTH, PHASE_W defaults and state enum {PREFILL, RUN}.
REQ-034 Sub-module phase_accum: registered acc, step input, strobe, outputs n and frac; cleared by reset or underrun.

Verification
REQ-035 Reset, 1023 in_valid, 3 strobes -> 3 out_valid with out_data=0, state=0; 1024th sample -> state=1 next cycle.
REQ-036 RUN, step=0x8000, in_valid and out_strobe every 8 cycles -> one dequeue per strobe, out_data = input order, level constant at 1024.
REQ-037 step=0x4000, 4 strobes -> n=0,1,0,1; 2 dequeues; each sample output twice.
REQ-038 step=0xC000, 4 strobes -> n=1,2,1,2; 6 dequeues; latencies 3,4,3,4 cycles.
REQ-039 Stop in_valid, strobes continue -> level reaches 0, underrun=1, state=0, out_data=0; clear_flags -> underrun=0.
REQ-040 No strobes, 2049 in_valid after reset -> level=2048, last sample not enqueued, overrun=1.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults and types for the FIFO rate controller.
// Holds the default sample/FIFO/phase widths, the prefill threshold default,
// the controller state enum and the sizing of the strobe-tracking queue.
package fifo_ctrl_pkg;

    localparam int unsigned DATA_W_DEF  = 12;
    localparam int unsigned DEPTH_DEF   = 2048;
    localparam int unsigned PREFILL_DEF = 1024;
    localparam int unsigned PHASE_W_DEF = 16;

    // Pending-dequeue counter width (saturates at 7).
    localparam int unsigned PEND_W = 3;

    // Strobes whose output is still outstanding, tracked in arrival order.
    localparam int unsigned SQ_DEPTH = 4;
    localparam int unsigned SQ_CNT_W = $clog2(SQ_DEPTH + 1);

    typedef enum logic {
        PREFILL = 1'b0,
        RUN     = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/fifo_rate_ctrl_phase_accum.sv
// Fractional phase accumulator for the resampler.
// Ports:
//   clock, reset  - clock, synchronous active-high reset
//   clear         - forces the accumulator to zero (wins over strobe)
//   strobe        - advance the accumulator by step this cycle
//   step          - unsigned Q1.15 increment, 0x8000 = one sample
//   n             - whole samples crossed by this advance (0..2), 0 without strobe
//   frac          - registered fractional accumulator
module phase_accum
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned PHASE_W = PHASE_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               strobe,
    input  logic [PHASE_W-1:0] step,
    output logic [1:0]         n,
    output logic [PHASE_W-2:0] frac
);

    localparam int unsigned FRAC_W = PHASE_W - 1;
    localparam int unsigned SUM_W  = PHASE_W + 1;

    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0]  sum;

    // Integer part of acc+step gives the number of input samples consumed.
    always_comb begin
        sum   = SUM_W'(acc_q) + SUM_W'(step);
        acc_d = acc_q;
        n     = 2'd0;
        if (strobe) begin
            acc_d = sum[FRAC_W-1:0];
            n     = sum[SUM_W-1:SUM_W-2];
        end
        if (clear) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign frac = acc_q;

endmodule

// File: rtl/fifo_rate_ctrl.sv
// Rate controller between an input sample stream and an output-rate strobe.
// Writes samples into an external FIFO, waits for a prefill level, then on
// each output strobe dequeues 0..2 samples according to a Q1.15 phase step
// and emits one output sample per strobe.
// Ports:
//   clock, reset                      - clock, synchronous active-high reset
//   in_valid, in_data                 - input sample stream
//   out_strobe, step                  - output-rate tick and resample ratio
//   clear_flags                       - clears overrun/underrun
//   fifo_enqueue, fifo_data_in        - FIFO write side (combinational)
//   fifo_dequeue                      - FIFO read request (combinational)
//   fifo_data_out, fifo_data_valid    - FIFO read data, one cycle after dequeue
//   fifo_full, fifo_empty             - FIFO status
//   out_valid, out_data               - one output pulse per strobe
//   level, state                      - occupancy and PREFILL(0)/RUN(1)
//   overrun, underrun                 - sticky error flags
module fifo_rate_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned PREFILL = PREFILL_DEF,
    parameter int unsigned PHASE_W = PHASE_W_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       out_strobe,
    input  logic [PHASE_W-1:0]         step,
    input  logic                       clear_flags,
    output logic                       fifo_enqueue,
    output logic                       fifo_dequeue,
    output logic [DATA_W-1:0]          fifo_data_in,
    input  logic [DATA_W-1:0]          fifo_data_out,
    input  logic                       fifo_data_valid,
    input  logic                       fifo_full,
    input  logic                       fifo_empty,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       state,
    output logic                       overrun,
    output logic                       underrun
);

    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    ctrl_state_e                       state_q, state_d;
    logic [LVL_W-1:0]                  level_q, level_d;
    logic [PEND_W-1:0]                 pend_q, pend_d;
    logic [DATA_W-1:0]                 held_q, held_d;
    logic                              out_valid_q, out_valid_d;
    logic [DATA_W-1:0]                 out_data_q, out_data_d;
    logic                              overrun_q, overrun_d;
    logic                              underrun_q, underrun_d;
    logic [SQ_DEPTH-1:0][1:0]          rem_q, rem_d;
    logic [SQ_CNT_W-1:0]               cnt_q, cnt_d;

    logic                              run;
    logic                              enq_c;
    logic                              deq_c;
    logic                              urun_evt;
    logic                              acc_strobe;
    logic [1:0]                        acc_n;
    logic [PHASE_W-2:0]                acc_frac;
    logic [1:0]                        n_eff;
    logic [PEND_W:0]                   pend_sum;
    logic                              arr;
    logic                              hit_head;
    logic                              tgt_found;
    logic                              done;
    logic [SQ_DEPTH-1:0][1:0]          rem_t;
    logic [SQ_CNT_W-1:0]               cnt_after;

    assign run        = (state_q == fifo_ctrl_pkg::RUN);
    assign acc_strobe = out_strobe && run;

    phase_accum #(
        .PHASE_W (PHASE_W)
    ) u_phase_accum (
        .clock  (clock),
        .reset  (reset),
        .clear  (urun_evt),
        .strobe (acc_strobe),
        .step   (step),
        .n      (acc_n),
        .frac   (acc_frac)
    );

    // Datapath, occupancy, pending dequeues, flags and state transition.
    always_comb begin
        enq_c    = in_valid && !fifo_full && (level_q < LVL_W'(DEPTH)) && !reset;
        deq_c    = run && (pend_q != '0) && (level_q != '0) && !fifo_empty && !reset;
        urun_evt = run && (pend_q != '0) && (level_q == '0);
        n_eff    = (run && !urun_evt) ? acc_n : 2'd0;

        level_d = level_q;
        if (enq_c && !deq_c) begin
            level_d = level_q + LVL_W'(1);
        end else if (!enq_c && deq_c) begin
            level_d = level_q - LVL_W'(1);
        end

        pend_sum = (PEND_W+1)'(pend_q) + (PEND_W+1)'(n_eff) - (PEND_W+1)'(deq_c);
        pend_d   = (pend_sum > (PEND_W+1)'(7)) ? PEND_W'(7) : pend_sum[PEND_W-1:0];
        if (urun_evt) begin
            pend_d = '0;
        end

        state_d = state_q;
        case (state_q)
            fifo_ctrl_pkg::PREFILL: if (level_d >= LVL_W'(PREFILL)) state_d = fifo_ctrl_pkg::RUN;
            fifo_ctrl_pkg::RUN:     if (urun_evt) state_d = fifo_ctrl_pkg::PREFILL;
            default:                state_d = fifo_ctrl_pkg::PREFILL;
        endcase

        // A same-cycle set event wins over clear_flags.
        overrun_d  = (in_valid && !enq_c) ? 1'b1 : (clear_flags ? 1'b0 : overrun_q);
        underrun_d = urun_evt ? 1'b1 : (clear_flags ? 1'b0 : underrun_q);

        held_d = fifo_data_valid ? fifo_data_out : held_q;
    end

    // Strobe tracking: each queued strobe counts down the FIFO reads it still
    // awaits; the head emits its output once its count reaches zero.
    always_comb begin
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        rem_t       = rem_q;
        cnt_after   = cnt_q;
        hit_head    = 1'b0;
        tgt_found   = 1'b0;
        done        = 1'b0;
        arr         = fifo_data_valid && run && !urun_evt;

        // Read data returns in dequeue order: credit the oldest strobe still waiting.
        for (int i = 0; i < int'(SQ_DEPTH); i++) begin
            if (arr && !tgt_found && (SQ_CNT_W'(i) < cnt_q) && (rem_q[i] != 2'd0)) begin
                rem_t[i]  = rem_q[i] - 2'd1;
                tgt_found = 1'b1;
                hit_head  = (i == 0);
            end
        end

        if (urun_evt) begin
            // Strobes starved of data are released as zero samples, one per cycle.
            for (int i = 0; i < int'(SQ_DEPTH); i++) begin
                rem_t[i] = 2'd0;
            end
        end else if ((cnt_q != '0) && (rem_t[0] == 2'd0)) begin
            done        = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = hit_head ? fifo_data_out : held_q;
            if (!run) begin
                out_data_d = '0;
            end
            for (int i = 0; i < int'(SQ_DEPTH) - 1; i++) begin
                rem_t[i] = rem_t[i+1];
            end
            rem_t[SQ_DEPTH-1] = 2'd0;
            cnt_after         = cnt_q - SQ_CNT_W'(1);
        end

        // A strobe needing no reads and with nothing ahead of it answers next cycle.
        if (out_strobe) begin
            if (!done && (cnt_after == '0) && (n_eff == 2'd0)) begin
                out_valid_d = 1'b1;
                out_data_d  = (run && !urun_evt) ? held_q : '0;
            end else if (cnt_after < SQ_CNT_W'(SQ_DEPTH)) begin
                for (int i = 0; i < int'(SQ_DEPTH); i++) begin
                    if (SQ_CNT_W'(i) == cnt_after) begin
                        rem_t[i] = n_eff;
                    end
                end
                cnt_after = cnt_after + SQ_CNT_W'(1);
            end
        end

        rem_d = rem_t;
        cnt_d = cnt_after;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= fifo_ctrl_pkg::PREFILL;
            level_q     <= '0;
            pend_q      <= '0;
            held_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            rem_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            pend_q      <= pend_d;
            held_q      <= held_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
        end
    end

    // The accumulator only advances in RUN and is cleared on entry to PREFILL.
    assert property (@(posedge clock) disable iff (reset)
        (state_q == fifo_ctrl_pkg::PREFILL) |-> (acc_frac == '0));

    assign fifo_enqueue = enq_c;
    assign fifo_dequeue = deq_c;
    assign fifo_data_in = in_data;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign level        = level_q;
    assign state        = state_q;
    assign overrun      = overrun_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_fifo_rate_ctrl.sv
// Directed bench for fifo_rate_ctrl with a behavioural one-cycle-latency FIFO.
`timescale 1ns/1ps
module tb_fifo_rate_ctrl;

    localparam int unsigned DW  = 12;
    localparam int unsigned DEP = 2048;
    localparam int unsigned PW  = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_strobe;
    logic [PW-1:0] step;
    logic          clear_flags;
    logic          fifo_enqueue;
    logic          fifo_dequeue;
    logic [DW-1:0] fifo_data_in;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_data_valid;
    logic          fifo_full;
    logic          fifo_empty;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [11:0]   level;
    logic          state;
    logic          overrun;
    logic          underrun;

    fifo_rate_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .out_strobe      (out_strobe),
        .step            (step),
        .clear_flags     (clear_flags),
        .fifo_enqueue    (fifo_enqueue),
        .fifo_dequeue    (fifo_dequeue),
        .fifo_data_in    (fifo_data_in),
        .fifo_data_out   (fifo_data_out),
        .fifo_data_valid (fifo_data_valid),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .level           (level),
        .state           (state),
        .overrun         (overrun),
        .underrun        (underrun)
    );

    always #5 clock = ~clock;

    // Behavioural FIFO, reset by the same reset, read data one cycle after dequeue.
    logic [DW-1:0] mem [DEP];
    logic [10:0]   wp, rp;
    logic [11:0]   fcnt;
    logic          f_wr, f_rd;
    assign fifo_full  = (fcnt == 12'd2048);
    assign fifo_empty = (fcnt == 12'd0);
    assign f_wr = fifo_enqueue && !fifo_full;
    assign f_rd = fifo_dequeue && !fifo_empty;

    always @(posedge clock) begin
        if (reset) begin
            wp <= '0; rp <= '0; fcnt <= '0;
            fifo_data_valid <= 1'b0; fifo_data_out <= '0;
        end else begin
            fifo_data_valid <= f_rd;
            if (f_wr) begin mem[wp] <= fifo_data_in; wp <= wp + 11'd1; end
            if (f_rd) begin fifo_data_out <= mem[rp]; rp <= rp + 11'd1; end
            fcnt <= fcnt + {11'd0, f_wr} - {11'd0, f_rd};
        end
    end

    // Output monitor: records output data, strobe-to-output latency, dequeues.
    int cyc = 0;
    int sq[$];
    int lat[$];
    int dq[$];
    int n_ov = 0, n_deq = 0, n_str = 0;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (!reset) begin
            if (out_strobe) begin sq.push_back(cyc); n_str++; end
            if (fifo_dequeue) n_deq++;
            if (out_valid) begin
                n_ov++;
                dq.push_back(int'(out_data));
                if (sq.size() > 0) lat.push_back(cyc - sq.pop_front());
                else lat.push_back(-1);
            end
        end
    end

    int total = 0, bad = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dq_at(input int i);
        if (i >= 0 && i < dq.size()) return dq[i];
        return -1;
    endfunction

    function automatic int lat_at(input int i);
        if (i >= 0 && i < lat.size()) return lat[i];
        return -1;
    endfunction

    task automatic cyc1(input logic v, input logic [DW-1:0] d, input logic s);
        in_valid = v; in_data = d; out_strobe = s;
        @(posedge clock); #1;
        in_valid = 1'b0; out_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc1(1'b0, '0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    int b, d0, s0, o0;
    logic s;
    int exp_u[4]  = '{1, 2, 3, 4};
    int exp_q[4]  = '{4, 5, 5, 6};
    int lat_q[4]  = '{1, 3, 1, 3};
    int exp_c[4]  = '{7, 9, 10, 12};
    int lat_c[4]  = '{3, 4, 3, 4};

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_strobe = 1'b0;
        step = 16'h8000; clear_flags = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_state", state, 0);
        chk("rst_level", level, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_dequeue", fifo_dequeue, 0);
        reset = 1'b0;

        // Prefill: 1023 samples with three strobes, all answered with zero.
        b = dq.size();
        for (int i = 0; i < 1023; i++) begin
            s = (i == 100) || (i == 400) || (i == 800);
            if (i == 5) begin
                in_valid = 1'b1; in_data = 12'd6; #1;
                chk("enq_pass", fifo_enqueue, 1);
                chk("enq_data", fifo_data_in, 6);
            end
            cyc1(1'b1, DW'(i + 1), s);
            if (s) begin
                chk("pf_out_valid", out_valid, 1);
                chk("pf_out_data", out_data, 0);
            end
        end
        chk("pf_out_cnt", dq.size() - b, 3);
        chk("pf_state", state, 0);
        chk("pf_level", level, 1023);
        chk("pf_no_deq", n_deq, 0);
        cyc1(1'b1, DW'(1024), 1'b0);
        chk("run_state", state, 1);
        chk("run_level", level, 1024);

        // Unity ratio: one dequeue per strobe, data in input order.
        step = 16'h8000; b = dq.size(); d0 = n_deq;
        for (int k = 0; k < 4; k++) begin
            cyc1(1'b1, DW'(1025 + k), 1'b1);
            idle(7);
            chk("u_level", level, 1024);
        end
        for (int k = 0; k < 4; k++) begin
            chk("u_data", dq_at(b + k), exp_u[k]);
            chk("u_lat", lat_at(b + k), 3);
        end
        chk("u_deq", n_deq - d0, 4);

        // Half ratio: n = 0,1,0,1.
        step = 16'h4000; b = dq.size(); d0 = n_deq;
        for (int k = 0; k < 4; k++) begin
            cyc1(1'b0, '0, 1'b1);
            idle(7);
        end
        for (int k = 0; k < 4; k++) begin
            chk("q_data", dq_at(b + k), exp_q[k]);
            chk("q_lat", lat_at(b + k), lat_q[k]);
        end
        chk("q_deq", n_deq - d0, 2);

        // 1.5 ratio: n = 1,2,1,2.
        step = 16'hC000; b = dq.size(); d0 = n_deq;
        for (int k = 0; k < 4; k++) begin
            cyc1(1'b0, '0, 1'b1);
            idle(7);
        end
        for (int k = 0; k < 4; k++) begin
            chk("c_data", dq_at(b + k), exp_c[k]);
            chk("c_lat", lat_at(b + k), lat_c[k]);
        end
        chk("c_deq", n_deq - d0, 6);
        chk("c_level", level, 1016);

        // Starve the FIFO until it underruns.
        step = 16'hFFFF; s0 = n_str; o0 = n_ov;
        for (int k = 0; k < 800 && !underrun; k++) begin
            cyc1(1'b0, '0, 1'b1);
            idle(3);
        end
        idle(8);
        chk("ur_flag", underrun, 1);
        chk("ur_state", state, 0);
        chk("ur_level", level, 0);
        chk("ur_last_data", dq_at(dq.size() - 1), 0);
        chk("ur_one_out_per_strobe", n_ov - o0, n_str - s0);
        clear_flags = 1'b1;
        cyc1(1'b0, '0, 1'b0);
        clear_flags = 1'b0;
        chk("ur_clear", underrun, 0);

        // Overrun after reset: 2049 samples, no strobes.
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("rst2_level", level, 0);
        chk("rst2_state", state, 0);
        for (int i = 0; i < 2048; i++) cyc1(1'b1, DW'(i), 1'b0);
        chk("ov_level_full", level, 2048);
        chk("ov_flag_before", overrun, 0);
        in_valid = 1'b1; in_data = 12'hABC; #1;
        chk("ov_no_enq", fifo_enqueue, 0);
        cyc1(1'b1, 12'hABC, 1'b0);
        chk("ov_flag", overrun, 1);
        chk("ov_level_held", level, 2048);
        clear_flags = 1'b1;
        cyc1(1'b1, '0, 1'b0);
        clear_flags = 1'b0;
        chk("ov_set_wins", overrun, 1);
        clear_flags = 1'b1;
        cyc1(1'b0, '0, 1'b0);
        clear_flags = 1'b0;
        chk("ov_clear", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
